cordic_iter_rotator: RTL and testbench
======================================

# cordic_iter_rotator

Iterative CORDIC rotation engine. A single shift-add micro-rotation datapath is reused over ITER clock cycles, sequenced by an internal FSM and iteration counter. Each accepted (x, y, theta) sample is rotated by theta. Sits beside the unrolled pipelined rotator as the low-area option: one sample in flight, valid/ready on both sides.

## Interface
- DW, 16: signed width of x/y samples.
- AW, DW: signed width of angle, Q1.(AW-1); [-1.0, 1.0) maps to [-pi, pi).
- ITER, 14: micro-rotations per sample; legal range 1..AW-1.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine can accept a sample.
- x_in, y_in  in  DW  signed input vector.
- theta_in  in  AW  signed rotation angle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- x_out, y_out  out  DW  signed rotated vector.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, COMP (only with macro), DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, registers are loaded with pre-rotated values and the FSM goes to RUN with cnt=0.
- Pre-rotation uses Q = 2^(AW-2), which represents +90 deg.
  - theta_in >= Q: x0=-y_in, y0=x_in, a0=theta_in-Q.
  - theta_in < -Q: x0=y_in, y0=-x_in, a0=theta_in+Q.
  - Otherwise the inputs pass unchanged.
- RUN, one micro-rotation per cycle, i=cnt:
  - If a>=0: x-=y>>>i, y+=x>>>i, a-=ATAN[i].
  - Else: x+=y>>>i, y-=x>>>i, a+=ATAN[i].
  - Both updates use the old x and y values.
- ATAN[i] = round(atan(2^-i)/pi * 2^(AW-1)). Elaborated as constants, with one entry per i in 0..ITER-1.
- When cnt==ITER-1, the FSM leaves RUN: to COMP if the macro is defined, else to DONE.
- DONE: out_valid=1. x_out/y_out are held stable until out_valid&&out_ready, then the FSM returns to IDLE.
- in_ready=0 in every state except IDLE. There is no same-cycle accept after output handoff.
- Arithmetic is DW-bit two's complement, wrapping, with no saturation. The caller keeps the input magnitude below 0.6*2^(DW-1) so that gain growth (≈1.6468) cannot overflow.
- Negating -2^(DW-1) in pre-rotation wraps; this input is out of contract.
- The angle accumulator is AW bits and wraps.

## Timing
- Reset (async assert, sync release) clears the following:
  - state=IDLE, cnt=0, x/y/a registers=0.
  - x_out=0, y_out=0, out_valid=0, busy=0.
  - in_ready=1 once reset is released.
- Reset asserted mid-RUN, mid-COMP or in DONE aborts the sample; no output is produced.
- Latency: out_valid rises ITER cycles after the accept edge, or ITER+1 cycles with the macro.
- Throughput: one sample per ITER+2 cycles when out_ready is held high (ITER+3 with the macro).
- in_valid while busy is ignored; the upstream holds the sample, per standard valid/ready.
- out_ready while out_valid=0 has no effect.
- Residual angle error after ITER steps is ≤ ATAN[ITER-1] + ITER LSB. The result error is within ±(ITER/2+2) LSB of ideal.

## Configuration
- CORDIC_ITER_GAIN_COMP_EN defined:
  - The COMP state adds one cycle.
  - Each output is multiplied by K = round(0.6072529350 * 2^(DW-1)) using a (2*DW)-bit product, then arithmetically shifted right by DW-1 and truncated to DW bits.
  - Net gain is ≈1.0.
- CORDIC_ITER_GAIN_COMP_EN undefined:
  - There is no COMP state and no multiplier.
  - Outputs carry the CORDIC gain ≈1.6468.

## Test plan
(DW=16, AW=16, ITER=14.)
- Zero angle: x=16384, y=0, theta=0, no macro.
  - Required: x_out=26981±8, y_out=0±8.
  - Required: out_valid exactly 14 cycles after the accept edge.
- +90 deg path: x=10000, y=0, theta=16384 (+90 deg), no macro.
  - Required: x_out=0±8, y_out=16468±8.
  - Confirms the pre-rotation branch.
- -180 deg: x=10000, y=0, theta=-32768.
  - No macro: x_out=-16468±8, y_out=0±8.
  - Macro defined: x_out=-10000±8, with latency of 15 cycles.
- Backpressure: out_ready held low for 5 cycles after out_valid.
  - Required: out_valid, x_out and y_out stable.
  - Required: in_ready=0, and an in_valid pulse during that window is not accepted.
  - Required: in_ready=1 on the cycle after the handoff.
- Reset mid-operation: assert rst_n=0 at cnt=6.
  - Required: out_valid=0, x_out=y_out=0, busy=0 immediately, asynchronously.
  - Required: after release, a new sample x=16384, theta=8192 (+45 deg) gives x_out=y_out=19079±8 (no macro).

Source files
------------

// File: rtl/cordic_iter_rotator.sv
// -----------------------------------------------------------------------------
// cordic_iter_rotator
//
// Iterative CORDIC rotation engine. One shift-add micro-rotation datapath is
// reused for ITER cycles per sample. Only one sample is in flight at a time,
// and both sides use a valid/ready handshake. This is the low-area companion to
// the unrolled, pipelined rotator.
//
// Angles are Q1.(AW-1): [-1.0, 1.0) maps to [-pi, pi). A fixed +/-90 degree
// pre-rotation brings |theta| inside the CORDIC convergence range.
//
// Optional feature macro: CORDIC_ITER_GAIN_COMP_EN
//   defined   : a COMP state adds one cycle. In that cycle both outputs are
//               scaled by K = 1/1.6468, giving a net gain of about 1.0.
//   undefined : there is no COMP state and no multiplier. Outputs carry the
//               CORDIC gain of about 1.6468.
//
// Parameters
//   DW   : signed width of the x/y samples
//   AW   : signed width of the angle (Q1.(AW-1)), 2..31
//   ITER : micro-rotations per sample, 1..AW-1
//
// Ports
//   i_clk        clock; all state changes happen on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   input sample valid
//   o_in_ready   engine can accept a sample (IDLE only)
//   i_x_in       signed input vector, x component
//   i_y_in       signed input vector, y component
//   i_theta_in   signed rotation angle
//   o_out_valid  result valid (DONE)
//   i_out_ready  downstream accepts the result
//   o_x_out      rotated vector, x component
//   o_y_out      rotated vector, y component
//   o_busy       high in any state other than IDLE
//
// State table
//   state  | meaning
//   IDLE   | waiting for a sample; o_in_ready=1
//   RUN    | one micro-rotation per cycle, cnt = 0..ITER-1
//   COMP   | gain-compensation multiply (only with CORDIC_ITER_GAIN_COMP_EN)
//   DONE   | result presented; held until o_out_valid && i_out_ready
// -----------------------------------------------------------------------------
module cordic_iter_rotator #(
  parameter int DW   = 16,
  parameter int AW   = DW,
  parameter int ITER = 14
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic signed [DW-1:0] i_x_in,
  input  logic signed [DW-1:0] i_y_in,
  input  logic signed [AW-1:0] i_theta_in,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic signed [DW-1:0] o_x_out,
  output logic signed [DW-1:0] o_y_out,
  output logic                 o_busy
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  // +90 degrees in Q1.(AW-1), and its negation.
  localparam logic signed [AW-1:0] ANG_P90 = AW'(1) << (AW - 2);
  localparam logic signed [AW-1:0] ANG_M90 = -ANG_P90;

  // The arctangent table is held at Q31 resolution and rounded down to AW bits
  // at elaboration. The result is a constant per iteration index.
  localparam int          ATAN_SH  = 32 - AW;
  localparam logic [31:0] ATAN_RND = (ATAN_SH > 0) ? (32'd1 << (ATAN_SH - 1)) : 32'd0;

  // round(atan(2^-i) / pi * 2^31)
  function automatic logic [31:0] atan_q31(input int idx);
    logic [31:0] v;
    v = 32'd0;
    case (idx)
      0:  v = 32'd536870912;
      1:  v = 32'd316933406;
      2:  v = 32'd167458907;
      3:  v = 32'd85004756;
      4:  v = 32'd42667331;
      5:  v = 32'd21354465;
      6:  v = 32'd10679838;
      7:  v = 32'd5340245;
      8:  v = 32'd2670163;
      9:  v = 32'd1335087;
      10: v = 32'd667544;
      11: v = 32'd333772;
      12: v = 32'd166886;
      13: v = 32'd83443;
      14: v = 32'd41722;
      15: v = 32'd20861;
      16: v = 32'd10430;
      17: v = 32'd5215;
      18: v = 32'd2608;
      19: v = 32'd1304;
      20: v = 32'd652;
      21: v = 32'd326;
      22: v = 32'd163;
      23: v = 32'd81;
      24: v = 32'd41;
      25: v = 32'd20;
      26: v = 32'd10;
      27: v = 32'd5;
      28: v = 32'd3;
      29: v = 32'd1;
      30: v = 32'd1;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  logic signed [AW-1:0] w_atan_tab [ITER];

  for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
    assign w_atan_tab[gi] = AW'((atan_q31(gi) + ATAN_RND) >> ATAN_SH);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_COMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]        r_cnt;
  logic signed [DW-1:0] r_x;
  logic signed [DW-1:0] r_y;
  logic signed [AW-1:0] r_a;
  logic signed [DW-1:0] r_x_out;
  logic signed [DW-1:0] r_y_out;

  logic                 w_accept;
  logic                 w_last;

  logic signed [DW-1:0] w_x_pre;
  logic signed [DW-1:0] w_y_pre;
  logic signed [AW-1:0] w_a_pre;

  logic signed [DW-1:0] w_x_sh;
  logic signed [DW-1:0] w_y_sh;
  logic signed [AW-1:0] w_atan;
  logic signed [DW-1:0] w_x_nxt;
  logic signed [DW-1:0] w_y_nxt;
  logic signed [AW-1:0] w_a_nxt;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_last = 1'b1;
`ifdef CORDIC_ITER_GAIN_COMP_EN
          w_state_nxt = S_COMP;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_COMP: begin
`ifdef CORDIC_ITER_GAIN_COMP_EN
        w_state_nxt = S_DONE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Quadrant pre-rotation: this folds |theta| into the +/-90 degree range,
  // where the micro-rotations converge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_x_pre = i_x_in;
    w_y_pre = i_y_in;
    w_a_pre = i_theta_in;
    if (i_theta_in >= ANG_P90) begin
      w_x_pre = -i_y_in;
      w_y_pre = i_x_in;
      w_a_pre = i_theta_in - ANG_P90;
    end else if (i_theta_in < ANG_M90) begin
      w_x_pre = i_y_in;
      w_y_pre = -i_x_in;
      w_a_pre = i_theta_in + ANG_P90;
    end
  end

  // ---------------------------------------------------------------------------
  // Micro-rotation i = cnt. Both updates use the old x and y values.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_x_sh = r_x >>> r_cnt;
    w_y_sh = r_y >>> r_cnt;
    w_atan = w_atan_tab[r_cnt];
    if (!r_a[AW-1]) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_a_nxt = r_a - w_atan;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_a_nxt = r_a + w_atan;
    end
  end

`ifdef CORDIC_ITER_GAIN_COMP_EN
  // K = round(0.6072529350 * 2^(DW-1)), which is positive and fits in DW bits.
  localparam longint unsigned K_NUM = 64'd6072529350;
  localparam logic signed [2*DW-1:0] K_GAIN =
    (2*DW)'((K_NUM * (64'd1 << (DW - 1)) + 64'd5000000000) / 64'd10000000000);

  logic signed [2*DW-1:0] w_x_prod;
  logic signed [2*DW-1:0] w_y_prod;
  logic signed [DW-1:0]   w_x_cmp;
  logic signed [DW-1:0]   w_y_cmp;

  assign w_x_prod = (2*DW)'(r_x) * K_GAIN;
  assign w_y_prod = (2*DW)'(r_y) * K_GAIN;
  assign w_x_cmp  = DW'(w_x_prod >>> (DW - 1));
  assign w_y_cmp  = DW'(w_y_prod >>> (DW - 1));
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_a     <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_x   <= w_x_pre;
      r_y   <= w_y_pre;
      r_a   <= w_a_pre;
    end else if (r_state == S_RUN) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      r_a <= w_a_nxt;
      // The counter is cleared on the final step so that it never has to
      // represent ITER itself.
      if (w_last) begin
        r_cnt <= '0;
`ifndef CORDIC_ITER_GAIN_COMP_EN
        r_x_out <= w_x_nxt;
        r_y_out <= w_y_nxt;
`endif
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
`ifdef CORDIC_ITER_GAIN_COMP_EN
    else if (r_state == S_COMP) begin
      r_x_out <= w_x_cmp;
      r_y_out <= w_y_cmp;
    end
`endif
  end

  assign o_x_out = r_x_out;
  assign o_y_out = r_y_out;

endmodule

// File: tb/tb_cordic_iter_rotator.sv
module tb_cordic_iter_rotator;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int ITER = 14;
  localparam int TOL  = 8;

`ifdef CORDIC_ITER_GAIN_COMP_EN
  localparam int LAT       = ITER + 1;
  localparam int PERIOD    = ITER + 3;
  localparam int EXP_ZX    = 16384;
  localparam int EXP_P90Y  = 10000;
  localparam int EXP_M180X = -10000;
  localparam int EXP_45    = 11585;
  localparam int EXP_BPX   = 10000;
`else
  localparam int LAT       = ITER;
  localparam int PERIOD    = ITER + 2;
  localparam int EXP_ZX    = 26981;
  localparam int EXP_P90Y  = 16468;
  localparam int EXP_M180X = -16468;
  localparam int EXP_45    = 19079;
  localparam int EXP_BPX   = 16468;
`endif

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] x_in      = '0;
  logic signed [DW-1:0] y_in      = '0;
  logic signed [AW-1:0] theta_in  = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 busy;
  logic signed [DW-1:0] x_out;
  logic signed [DW-1:0] y_out;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  cordic_iter_rotator #(.DW(DW), .AW(AW), .ITER(ITER)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_x_in      (x_in),
    .i_y_in      (y_in),
    .i_theta_in  (theta_in),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_x_out     (x_out),
    .o_y_out     (y_out),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Presents one sample, waits for the accept edge, then counts edges until
  // out_valid is seen. lat is 100 if out_valid never rises.
  task automatic run_sample(input int x, input int y, input int th,
                            output int ox, output int oy, output int lat);
    @(negedge clk);
    x_in     = DW'(x);
    y_in     = DW'(y);
    theta_in = AW'(th);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ox = int'(x_out);
    oy = int'(y_out);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (x_out !== 16'sd0) $display("FAIL reset_x_out: got %0d want 0", x_out); else n_pass++;
    n_total++; if (y_out !== 16'sd0) $display("FAIL reset_y_out: got %0d want 0", y_out); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_zero_angle;
    int ox, oy, lat;
    out_ready = 1'b1;
    run_sample(16384, 0, 0, ox, oy, lat);
    n_total++; if (lat !== LAT) $display("FAIL zero_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (iabs(ox - EXP_ZX) > TOL) $display("FAIL zero_x: got %0d want %0d +/-%0d", ox, EXP_ZX, TOL); else n_pass++;
    n_total++; if (iabs(oy) > TOL) $display("FAIL zero_y: got %0d want 0 +/-%0d", oy, TOL); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL zero_in_ready_after: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_plus90;
    int ox, oy, lat;
    out_ready = 1'b1;
    run_sample(10000, 0, 16384, ox, oy, lat);
    n_total++; if (lat !== LAT) $display("FAIL p90_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (iabs(ox) > TOL) $display("FAIL p90_x: got %0d want 0 +/-%0d", ox, TOL); else n_pass++;
    n_total++; if (iabs(oy - EXP_P90Y) > TOL) $display("FAIL p90_y: got %0d want %0d +/-%0d", oy, EXP_P90Y, TOL); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_minus180;
    int ox, oy, lat;
    out_ready = 1'b1;
    run_sample(10000, 0, -32768, ox, oy, lat);
    n_total++; if (lat !== LAT) $display("FAIL m180_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (iabs(ox - EXP_M180X) > TOL) $display("FAIL m180_x: got %0d want %0d +/-%0d", ox, EXP_M180X, TOL); else n_pass++;
    n_total++; if (iabs(oy) > TOL) $display("FAIL m180_y: got %0d want 0 +/-%0d", oy, TOL); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int ox, oy, lat;
    out_ready = 1'b0;
    run_sample(10000, 0, 0, ox, oy, lat);
    n_total++; if (iabs(ox - EXP_BPX) > TOL) $display("FAIL bp_x: got %0d want %0d +/-%0d", ox, EXP_BPX, TOL); else n_pass++;
    n_total++; if (iabs(oy) > TOL) $display("FAIL bp_y: got %0d want 0 +/-%0d", oy, TOL); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        x_in     = 16'sd1234;
        y_in     = 16'sd0;
        theta_in = 16'sd0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, out_valid); else n_pass++;
      n_total++; if (int'(x_out) !== ox) $display("FAIL bp_hold_x[%0d]: got %0d want %0d", k, x_out, ox); else n_pass++;
      n_total++; if (int'(y_out) !== oy) $display("FAIL bp_hold_y[%0d]: got %0d want %0d", k, y_out, oy); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); else n_pass++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_after_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_after_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL bp_after_busy: got %b want 0 (pulse accepted)", busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int t1, t2, w;
    out_ready = 1'b1;
    @(negedge clk);
    x_in     = 16'sd16384;
    y_in     = 16'sd0;
    theta_in = 16'sd0;
    in_valid = 1'b1;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    t1 = cyc;
    while (out_valid && w < 200) begin @(posedge clk); #1; w++; end
    while (!out_valid && w < 300) begin @(posedge clk); #1; w++; end
    t2 = cyc;
    in_valid = 1'b0;
    n_total++; if (!out_valid) $display("FAIL b2b_timeout: got out_valid=%b want 1 within bound", out_valid); else n_pass++;
    n_total++; if ((t2 - t1) !== PERIOD) $display("FAIL b2b_period: got %0d want %0d", t2 - t1, PERIOD); else n_pass++;
    n_total++; if (iabs(int'(x_out) - EXP_ZX) > TOL) $display("FAIL b2b_x: got %0d want %0d +/-%0d", x_out, EXP_ZX, TOL); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int ox, oy, lat;
    out_ready = 1'b1;
    @(negedge clk);
    x_in     = 16'sd16384;
    y_in     = 16'sd0;
    theta_in = 16'sd8192;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (x_out !== 16'sd0) $display("FAIL mid_rst_x: got %0d want 0", x_out); else n_pass++;
    n_total++; if (y_out !== 16'sd0) $display("FAIL mid_rst_y: got %0d want 0", y_out); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(16384, 0, 8192, ox, oy, lat);
    n_total++; if (lat !== LAT) $display("FAIL p45_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_total++; if (iabs(ox - EXP_45) > TOL) $display("FAIL p45_x: got %0d want %0d +/-%0d", ox, EXP_45, TOL); else n_pass++;
    n_total++; if (iabs(oy - EXP_45) > TOL) $display("FAIL p45_y: got %0d want %0d +/-%0d", oy, EXP_45, TOL); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_angle();
    test_plus90();
    test_minus180();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
